// File: rtl/cbf_counter_sequencer.sv
// ---------------------------------------------------------------------------------------------
// cbf_counter_sequencer
//
// Request front-end for a counting Bloom filter counter bank. A request (query, insert or
// delete) carries a key. The block derives NUM_HASH counter indices from that key and visits
// one index per cycle. On each visit it either pulses the write enable of that counter, with
// the shared increment/decrement line set, or it only samples the counter's flags.
//
// The counters report their current value through two flags:
//   - zero : the counter holds zero.
//   - OF   : the counter is saturated.
// These flags decide membership for a query. They also block an insert into a saturated
// counter and a delete from an empty one. A blocked step does not write and sets the
// response's sat flag.
//
// Index derivation, for step i:
//   h_i = fold(rotl(key, i)) ^ i
// fold() XORs together all IDX_W-bit slices of its argument.
//
// Ports:
//   CLK           clock, rising edge active
//   rstb          asynchronous active-low reset
//   req_valid     request present
//   req_ready     request can be accepted (high only while idle)
//   req_op        00 query, 01 insert, 10 delete, 11 reserved
//   req_key       request key
//   ctr_WE        one-hot counter write enable (combinational)
//   ctr_Increment 1 = increment, 0 = decrement (combinational)
//   ctr_zero      per-counter zero flag
//   ctr_OF        per-counter saturated flag
//   resp_valid    one-cycle response strobe
//   resp_hit      query result (held until the next response)
//   resp_sat      some step was blocked by a guard (held)
//   resp_err      reserved opcode seen (held)
// ---------------------------------------------------------------------------------------------
module cbf_counter_sequencer #(
    parameter int unsigned KEY_W    = 16,
    parameter int unsigned IDX_W    = 4,
    parameter int unsigned NUM_HASH = 3,
    localparam int unsigned NCTR    = 1 << IDX_W
) (
    input  logic             CLK,
    input  logic             rstb,

    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [KEY_W-1:0] req_key,

    output logic [NCTR-1:0]  ctr_WE,
    output logic             ctr_Increment,
    input  logic [NCTR-1:0]  ctr_zero,
    input  logic [NCTR-1:0]  ctr_OF,

    output logic             resp_valid,
    output logic             resp_hit,
    output logic             resp_sat,
    output logic             resp_err
);

    localparam logic [1:0] OpQuery  = 2'b00;
    localparam logic [1:0] OpInsert = 2'b01;
    localparam logic [1:0] OpDelete = 2'b10;
    localparam logic [1:0] OpRsvd   = 2'b11;

    localparam logic [IDX_W-1:0] LastStep = IDX_W'(NUM_HASH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StStep,
        StResp
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   step_q, step_d;
    logic [KEY_W-1:0]   key_q, key_d;
    logic [1:0]         op_q, op_d;
    logic               hit_acc_q, hit_acc_d;
    logic               sat_acc_q, sat_acc_d;
    logic               resp_hit_q, resp_hit_d;
    logic               resp_sat_q, resp_sat_d;
    logic               resp_err_q, resp_err_d;

    logic [IDX_W-1:0]   cur_idx;
    logic               is_last;

    // h_i computed from the latched key and the current step number.
    function automatic logic [IDX_W-1:0] hash_idx(input logic [KEY_W-1:0] key,
                                                  input logic [IDX_W-1:0] i);
        logic [KEY_W-1:0] rot;
        logic [IDX_W-1:0] acc;
        rot = '0;
        for (int unsigned b = 0; b < KEY_W; b++) begin
            rot[(b + 32'(i)) % KEY_W] = key[b];
        end
        acc = i;
        for (int unsigned s = 0; s < KEY_W / IDX_W; s++) begin
            acc = acc ^ rot[s*IDX_W +: IDX_W];
        end
        return acc;
    endfunction

    assign cur_idx = hash_idx(key_q, step_q);
    assign is_last = (step_q == LastStep);

    always_comb begin
        state_d       = state_q;
        step_d        = step_q;
        key_d         = key_q;
        op_d          = op_q;
        hit_acc_d     = hit_acc_q;
        sat_acc_d     = sat_acc_q;
        resp_hit_d    = resp_hit_q;
        resp_sat_d    = resp_sat_q;
        resp_err_d    = resp_err_q;
        ctr_WE        = '0;
        ctr_Increment = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    key_d     = req_key;
                    op_d      = req_op;
                    step_d    = '0;
                    hit_acc_d = 1'b1;
                    sat_acc_d = 1'b0;
                    state_d   = StStep;
                end
            end

            StStep: begin
                unique case (op_q)
                    OpInsert: begin
                        if (ctr_OF[cur_idx]) begin
                            sat_acc_d = 1'b1;
                        end else begin
                            ctr_WE        = NCTR'(1) << cur_idx;
                            ctr_Increment = 1'b1;
                        end
                    end
                    OpDelete: begin
                        if (ctr_zero[cur_idx]) begin
                            sat_acc_d = 1'b1;
                        end else begin
                            ctr_WE = NCTR'(1) << cur_idx;
                        end
                    end
                    OpQuery: begin
                        hit_acc_d = hit_acc_q & ~ctr_zero[cur_idx];
                    end
                    default: begin
                        // Reserved opcode: a single silent cycle, so its response comes one
                        // cycle after acceptance plus one, with no counter activity.
                    end
                endcase

                if (is_last || (op_q == OpRsvd)) begin
                    state_d = StResp;
                    // Response flags are captured on entry to RESP and held afterwards.
                    resp_hit_d = (op_q == OpQuery) & hit_acc_d;
                    resp_sat_d = sat_acc_d;
                    resp_err_d = (op_q == OpRsvd);
                end else begin
                    step_d = step_q + 1'b1;
                end
            end

            StResp: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge rstb) begin
        if (!rstb) begin
            state_q    <= StIdle;
            step_q     <= '0;
            key_q      <= '0;
            op_q       <= '0;
            hit_acc_q  <= 1'b1;
            sat_acc_q  <= 1'b0;
            resp_hit_q <= 1'b0;
            resp_sat_q <= 1'b0;
            resp_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            key_q      <= key_d;
            op_q       <= op_d;
            hit_acc_q  <= hit_acc_d;
            sat_acc_q  <= sat_acc_d;
            resp_hit_q <= resp_hit_d;
            resp_sat_q <= resp_sat_d;
            resp_err_q <= resp_err_d;
        end
    end

    assign req_ready  = (state_q == StIdle);
    assign resp_valid = (state_q == StResp);
    assign resp_hit   = resp_hit_q;
    assign resp_sat   = resp_sat_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_cbf_counter_sequencer.sv
// ---------------------------------------------------------------------------------------------
// tb_cbf_counter_sequencer
//
// The bench has three parts:
//   - A behavioural counter bank of saturating counters (max MAXC). The DUT writes it, and it
//     drives the DUT's zero/OF flag inputs.
//   - A transaction-level reference model. When a request is accepted, the model computes the
//     whole expected cycle trace from the hash formula and its own copy of the counter values.
//   - One compare process. At every falling edge it checks every DUT output against the model.
//
// Directed requests also carry hand-computed literal expectations.
// ---------------------------------------------------------------------------------------------
module tb_cbf_counter_sequencer;

    localparam int KEY_W = 16;
    localparam int IDX_W = 4;
    localparam int NH    = 3;
    localparam int NCTR  = 16;
    localparam int MAXC  = 3;

    logic              CLK = 1'b0;
    logic              rstb = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [1:0]        req_op = 2'b00;
    logic [KEY_W-1:0]  req_key = '0;
    logic [NCTR-1:0]   ctr_WE;
    logic              ctr_Increment;
    logic [NCTR-1:0]   ctr_zero;
    logic [NCTR-1:0]   ctr_OF;
    logic              resp_valid, resp_hit, resp_sat, resp_err;

    int checks = 0;
    int errors = 0;

    cbf_counter_sequencer #(
        .KEY_W    (KEY_W),
        .IDX_W    (IDX_W),
        .NUM_HASH (NH)
    ) dut (
        .CLK           (CLK),
        .rstb          (rstb),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_op        (req_op),
        .req_key       (req_key),
        .ctr_WE        (ctr_WE),
        .ctr_Increment (ctr_Increment),
        .ctr_zero      (ctr_zero),
        .ctr_OF        (ctr_OF),
        .resp_valid    (resp_valid),
        .resp_hit      (resp_hit),
        .resp_sat      (resp_sat),
        .resp_err      (resp_err)
    );

    always #5 CLK = ~CLK;

    // Counter bank: unaffected by rstb, so updates survive a sequencer reset.
    int   phys [NCTR];
    logic poke_en = 1'b0;
    int   poke_idx = 0;
    int   poke_val = 0;

    always @(posedge CLK) begin
        if (poke_en) begin
            phys[poke_idx] <= poke_val;
        end else begin
            for (int k = 0; k < NCTR; k++) begin
                if (ctr_WE[k]) begin
                    if (ctr_Increment) phys[k] <= (phys[k] < MAXC) ? phys[k] + 1 : phys[k];
                    else               phys[k] <= (phys[k] > 0) ? phys[k] - 1 : 0;
                end
            end
        end
    end

    always_comb begin
        ctr_zero = '0;
        ctr_OF   = '0;
        for (int k = 0; k < NCTR; k++) begin
            ctr_zero[k] = (phys[k] == 0);
            ctr_OF[k]   = (phys[k] == MAXC);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [NCTR-1:0] we;
        logic            inc;
        logic            rv;
        logic            hit;
        logic            sat;
        logic            err;
        logic            wr;
        logic [3:0]      widx;
    } exp_t;

    exp_t expq[$];
    int   mbank [NCTR];
    logic last_hit = 1'b0, last_sat = 1'b0, last_err = 1'b0;

    function automatic int hidx(input int key, input int i);
        int r, rot, acc;
        r   = i % KEY_W;
        rot = ((key << r) | (key >> (KEY_W - r))) & 32'hFFFF;
        acc = i & 32'hF;
        for (int j = 0; j < KEY_W / IDX_W; j++) acc = acc ^ ((rot >> (4 * j)) & 32'hF);
        return acc;
    endfunction

    task automatic build(input logic [1:0] op, input int key);
        int   tmp [NCTR];
        int   h;
        logic hit, sat;
        exp_t e;
        for (int k = 0; k < NCTR; k++) tmp[k] = mbank[k];
        hit = 1'b1;
        sat = 1'b0;
        if (op == 2'b11) begin
            e = '0;
            expq.push_back(e);
            e.rv  = 1'b1;
            e.err = 1'b1;
            expq.push_back(e);
        end else begin
            for (int i = 0; i < NH; i++) begin
                e = '0;
                h = hidx(key, i);
                if (op == 2'b00) begin
                    if (tmp[h] == 0) hit = 1'b0;
                end else if (op == 2'b01) begin
                    if (tmp[h] == MAXC) sat = 1'b1;
                    else begin
                        e.we = NCTR'(1) << h; e.inc = 1'b1; e.wr = 1'b1; e.widx = 4'(h);
                        tmp[h]++;
                    end
                end else begin
                    if (tmp[h] == 0) sat = 1'b1;
                    else begin
                        e.we = NCTR'(1) << h; e.wr = 1'b1; e.widx = 4'(h);
                        tmp[h]--;
                    end
                end
                expq.push_back(e);
            end
            e     = '0;
            e.rv  = 1'b1;
            e.hit = (op == 2'b00) ? hit : 1'b0;
            e.sat = sat;
            expq.push_back(e);
        end
    endtask

    // Compare process: one evaluation per falling edge.
    initial begin
        exp_t e;
        logic was_idle;
        forever begin
            @(negedge CLK);
            if (!rstb) begin
                expq.delete();
                last_hit = 1'b0; last_sat = 1'b0; last_err = 1'b0;
                chk("rst_we", ctr_WE, '0);
                chk("rst_inc", ctr_Increment, 0);
                chk("rst_rv", resp_valid, 0);
                chk("rst_ready", req_ready, 1);
            end else begin
                was_idle = (expq.size() == 0);
                if (!was_idle) begin
                    e = expq.pop_front();
                    chk("we", ctr_WE, e.we);
                    chk("inc", ctr_Increment, e.inc);
                    chk("rv", resp_valid, e.rv);
                    chk("ready_busy", req_ready, 0);
                    if (e.rv) begin
                        last_hit = e.hit; last_sat = e.sat; last_err = e.err;
                    end
                    if (e.wr) mbank[e.widx] = e.inc ? mbank[e.widx] + 1 : mbank[e.widx] - 1;
                end else begin
                    chk("idle_we", ctr_WE, '0);
                    chk("idle_inc", ctr_Increment, 0);
                    chk("idle_rv", resp_valid, 0);
                    chk("idle_ready", req_ready, 1);
                end
                if (was_idle && req_valid) build(req_op, int'(req_key));
            end
            chk("hit", resp_hit, last_hit);
            chk("sat", resp_sat, last_sat);
            chk("err", resp_err, last_err);
        end
    end

    // ---------------- driver ----------------
    logic [NCTR-1:0] cap_we [8];
    int              cap_rv_at;
    logic            cap_hit, cap_sat, cap_err;

    task automatic issue(input logic [1:0] op, input logic [15:0] key);
        int n;
        @(posedge CLK); #1;
        req_valid = 1'b1; req_op = op; req_key = key;
        n = 0;
        @(negedge CLK);
        while (!req_ready && n < 20) begin n++; @(negedge CLK); end
        chk("accept_wait", n < 20, 1);
        @(posedge CLK); #1;
        // Junk request while busy; it must be ignored.
        req_valid = 1'($urandom_range(0, 1));
        req_op    = 2'($urandom);
        req_key   = 16'($urandom);
        for (int k = 0; k < 8; k++) cap_we[k] = '0;
        cap_rv_at = -1;
        for (int k = 0; k < 8 && cap_rv_at < 0; k++) begin
            @(negedge CLK);
            cap_we[k] = ctr_WE;
            if (resp_valid) begin
                cap_rv_at = k; cap_hit = resp_hit; cap_sat = resp_sat; cap_err = resp_err;
            end
        end
        req_valid = 1'b0;
        chk("resp_wait", cap_rv_at >= 0, 1);
    endtask

    task automatic poke(input int idx, input int val);
        @(posedge CLK); #1;
        poke_en = 1'b1; poke_idx = idx; poke_val = val;
        mbank[idx] = val;
        @(posedge CLK); #1;
        poke_en = 1'b0;
    endtask

    task automatic start_and_reset(input logic [1:0] op, input logic [15:0] key, input int dly);
        @(posedge CLK); #1;
        req_valid = 1'b1; req_op = op; req_key = key;
        @(negedge CLK);
        @(posedge CLK); #1;
        req_valid = 1'b0;
        repeat (dly) @(posedge CLK);
        #2 rstb = 1'b0;
        #1;
        chk("arst_we", ctr_WE, '0);
        chk("arst_ready", req_ready, 1);
        chk("arst_rv", resp_valid, 0);
        chk("arst_flags", {resp_hit, resp_sat, resp_err}, 0);
        @(negedge CLK);
        @(posedge CLK); #1;
        rstb = 1'b1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] pool [6];
        int          r;
        logic [1:0]  op;

        // Pin the model's hash itself.
        chk("model_h", 32'(hidx(1, 1)), 3);
        chk("model_h2", 32'(hidx(1, 2)), 6);

        repeat (3) @(posedge CLK);
        #1 rstb = 1'b1;

        issue(2'b00, 16'h0000);
        chk("q0_we", {cap_we[0], cap_we[1], cap_we[2]}, '0);
        chk("q0_lat", cap_rv_at, NH);
        chk("q0_hitsat", {cap_hit, cap_sat}, 2'b00);

        issue(2'b01, 16'h0000);
        chk("i0_we0", cap_we[0], 16'h0001);
        chk("i0_we1", cap_we[1], 16'h0002);
        chk("i0_we2", cap_we[2], 16'h0004);
        chk("i0_lat", cap_rv_at, NH);

        issue(2'b00, 16'h0000);
        chk("q0b_hit", cap_hit, 1);

        issue(2'b01, 16'h0001);
        chk("i1_we", {cap_we[0], cap_we[1], cap_we[2]}, {16'h0002, 16'h0008, 16'h0040});

        poke(3, 0);
        issue(2'b10, 16'h0001);
        chk("d1_we", {cap_we[0], cap_we[1], cap_we[2]}, {16'h0002, 16'h0000, 16'h0040});
        chk("d1_sat", cap_sat, 1);

        poke(1, MAXC);
        issue(2'b01, 16'h0000);
        chk("i0of_we", {cap_we[0], cap_we[1], cap_we[2]}, {16'h0001, 16'h0000, 16'h0004});
        chk("i0of_sat", cap_sat, 1);

        issue(2'b11, 16'h1234);
        chk("rsv_lat", cap_rv_at, 1);
        chk("rsv_we", cap_we[0], '0);
        chk("rsv_flags", {cap_err, cap_hit}, 2'b10);

        // Reset during the second step of an insert.
        start_and_reset(2'b01, 16'h0000, 1);
        poke(1, 1);
        issue(2'b01, 16'h0001);
        chk("post_rst_we", {cap_we[0], cap_we[1], cap_we[2]}, {16'h0002, 16'h0008, 16'h0040});
        chk("post_rst_lat", cap_rv_at, NH);

        for (int k = 0; k < 6; k++) pool[k] = 16'($urandom);
        pool[0] = 16'h0000;
        for (int n = 0; n < 250; n++) begin
            r = int'($urandom_range(0, 19));
            if (r == 0) begin
                poke(int'($urandom_range(0, NCTR - 1)), int'($urandom_range(0, MAXC)));
            end else if (r == 1) begin
                start_and_reset(2'($urandom_range(0, 2)), pool[$urandom_range(0, 5)],
                                int'($urandom_range(0, 4)));
            end else begin
                op = (r == 2) ? 2'b11 : 2'($urandom_range(0, 2));
                issue(op, pool[$urandom_range(0, 5)]);
            end
        end

        repeat (3) @(posedge CLK);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
